// File: rtl/vga_color_out_if.sv
// Pixel, sync and palette-programming bundle between the CRTC line-buffer
// side and the final VGA colour stage.
interface vga_color_out_if;
    logic       dot_b;
    logic       dot_r;
    logic       dot_g;
    logic       lumi;
    logic       vsafe;
    logic       scanln;
    logic       scan_en;
    logic       mono_en;
    logic       hs_in;
    logic       vs_in;
    logic       plt_we;
    logic [2:0] plt_adr;
    logic [8:0] plt_data;
    logic       bg_we;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       plt_pending;

    modport master (
        output dot_b, dot_r, dot_g, lumi, vsafe, scanln, scan_en, mono_en,
               hs_in, vs_in, plt_we, plt_adr, plt_data, bg_we,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, plt_pending
    );

    modport slave (
        input  dot_b, dot_r, dot_g, lumi, vsafe, scanln, scan_en, mono_en,
               hs_in, vs_in, plt_we, plt_adr, plt_data, bg_we,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, plt_pending
    );
endinterface

// File: rtl/vga_color_out.sv
// Final VGA colour stage: palette lookup, mono/scanline/blanking, 4-bit RGB out,
// with palette updates shadowed and committed at the vsync falling edge.
module vga_color_out #(
    parameter int PIPE_LAT  = 3,
    parameter bit IMMEDIATE = 1'b0
) (
    input logic           clk,
    input logic           reset,
    vga_color_out_if.slave vif
);

    function automatic logic [3:0] expand(input logic [2:0] c);
        return {c, c[2]};
    endfunction

    function automatic logic [8:0] default_entry(input logic [2:0] i);
        return {{3{i[2]}}, {3{i[1]}}, {3{i[0]}}};
    endfunction

    logic [8:0]          active_q [8];
    logic [8:0]          shadow_q [8];
    logic [8:0]          bg_q;
    logic                pending_q, pending_d;
    logic [PIPE_LAT-1:0] hs_sr_q, vs_sr_q;
    logic                commit;

    logic [2:0] idx_s1_q;
    logic       lumi_s1_q, vsafe_s1_q, scanln_s1_q, scan_en_s1_q, mono_s1_q;
    logic [8:0] col_s2_q, col_d;
    logic       lumi_s2_q, vsafe_s2_q, scan_s2_q, mono_s2_q;
    logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d, mono_v;

    // vs_sr_q[0] is the S1 copy of vs_in, so this fires once per falling edge
    assign commit = vs_sr_q[0] & ~vif.vs_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= default_entry(3'(i));
                active_q[i] <= default_entry(3'(i));
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (commit) active_q[i] <= shadow_q[i];
            end
            if (vif.plt_we) begin
                shadow_q[vif.plt_adr] <= vif.plt_data;
                if (IMMEDIATE) active_q[vif.plt_adr] <= vif.plt_data;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (!IMMEDIATE && vif.plt_we) pending_d = 1'b1;
        else if (commit)              pending_d = 1'b0;
    end

    always_comb begin
        col_d = vif.plt_we ? 9'd0 : 9'd0;
        col_d = lumi_s1_q ? active_q[idx_s1_q] : bg_q;
    end

    always_comb begin
        r_d    = 4'h0;
        g_d    = 4'h0;
        b_d    = 4'h0;
        mono_v = lumi_s2_q ? 4'hF : expand(col_s2_q[8:6]);
        if (vsafe_s2_q) begin
            if (mono_s2_q) begin
                r_d = mono_v;
                g_d = mono_v;
                b_d = mono_v;
            end else begin
                r_d = expand(col_s2_q[5:3]);
                g_d = expand(col_s2_q[8:6]);
                b_d = expand(col_s2_q[2:0]);
            end
            if (scan_s2_q) begin
                r_d = r_d >> 1;
                g_d = g_d >> 1;
                b_d = b_d >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_q         <= '0;
            pending_q    <= 1'b0;
            hs_sr_q      <= '1;
            vs_sr_q      <= '1;
            idx_s1_q     <= '0;
            lumi_s1_q    <= 1'b0;
            vsafe_s1_q   <= 1'b0;
            scanln_s1_q  <= 1'b0;
            scan_en_s1_q <= 1'b0;
            mono_s1_q    <= 1'b0;
            col_s2_q     <= '0;
            lumi_s2_q    <= 1'b0;
            vsafe_s2_q   <= 1'b0;
            scan_s2_q    <= 1'b0;
            mono_s2_q    <= 1'b0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
        end else begin
            if (vif.bg_we) bg_q <= vif.plt_data;
            pending_q    <= pending_d;
            hs_sr_q      <= {hs_sr_q[PIPE_LAT-2:0], vif.hs_in};
            vs_sr_q      <= {vs_sr_q[PIPE_LAT-2:0], vif.vs_in};
            idx_s1_q     <= {vif.dot_g, vif.dot_r, vif.dot_b};
            lumi_s1_q    <= vif.lumi;
            vsafe_s1_q   <= vif.vsafe;
            scanln_s1_q  <= vif.scanln;
            scan_en_s1_q <= vif.scan_en;
            mono_s1_q    <= vif.mono_en;
            col_s2_q     <= col_d;
            lumi_s2_q    <= lumi_s1_q;
            vsafe_s2_q   <= vsafe_s1_q;
            scan_s2_q    <= scan_en_s1_q & scanln_s1_q;
            mono_s2_q    <= mono_s1_q;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
        end
    end

    assign vif.vga_r       = r_q;
    assign vif.vga_g       = g_q;
    assign vif.vga_b       = b_q;
    assign vif.vga_hs      = hs_sr_q[PIPE_LAT-1];
    assign vif.vga_vs      = vs_sr_q[PIPE_LAT-1];
    assign vif.plt_pending = pending_q;

endmodule

// File: tb/tb_vga_color_out.sv
// Randomised and directed bench for vga_color_out against a frame-level
// palette/colour model.
module tb_vga_color_out;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vga_color_out_if vif();

    vga_color_out #(.PIPE_LAT(3), .IMMEDIATE(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: palettes, background, pending flag, last sampled vsync,
    // and the three most recent expected {rgb, hs, vs} results.
    logic [8:0]  m_act [8];
    logic [8:0]  m_sh  [8];
    logic [8:0]  m_bg;
    logic        m_pend;
    logic        m_vsprev;
    logic [13:0] m_pipe [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ex4(input int c);
        return c * 2 + c / 4;
    endfunction

    function automatic logic [11:0] pix(input logic vsafe, input logic lumi, input logic mono,
                                        input logic scan, input logic [8:0] col);
        int r, g, b;
        if (!vsafe) return 12'h000;
        if (mono) begin
            r = lumi ? 15 : ex4(int'(col[8:6]));
            g = r;
            b = r;
        end else begin
            r = ex4(int'(col[5:3]));
            g = ex4(int'(col[8:6]));
            b = ex4(int'(col[2:0]));
        end
        if (scan) begin
            r = r / 2;
            g = g / 2;
            b = b / 2;
        end
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_act[i] = 9'(((i / 4) % 2) * 9'o700 + ((i / 2) % 2) * 9'o070 + (i % 2) * 9'o007);
            m_sh[i]  = m_act[i];
        end
        m_bg     = 9'd0;
        m_pend   = 1'b0;
        m_vsprev = 1'b1;
        for (int i = 0; i < 3; i++) m_pipe[i] = {12'h000, 2'b11};
    endtask

    task automatic model_edge();
        logic       commit;
        logic [8:0] col;
        commit = m_vsprev && !vif.vs_in;
        if (commit) for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        if (vif.plt_we) m_sh[vif.plt_adr] = vif.plt_data;
        if (vif.plt_we) m_pend = 1'b1;
        else if (commit) m_pend = 1'b0;
        if (vif.bg_we) m_bg = vif.plt_data;
        col = vif.lumi ? m_act[{vif.dot_g, vif.dot_r, vif.dot_b}] : m_bg;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = {pix(vif.vsafe, vif.lumi, vif.mono_en, vif.scan_en & vif.scanln, col),
                     vif.hs_in, vif.vs_in};
        m_vsprev = vif.vs_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("pix",  32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(m_pipe[2][13:2]));
        chk("sync", 32'({vif.vga_hs, vif.vga_vs}), 32'(m_pipe[2][1:0]));
        chk("pend", 32'(vif.plt_pending), 32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic px(input logic [2:0] idx);
        {vif.dot_g, vif.dot_r, vif.dot_b} = idx;
    endtask

    task automatic idle_inputs();
        px(3'd0);
        vif.lumi = 1'b1;  vif.vsafe = 1'b1;  vif.scanln = 1'b0;
        vif.scan_en = 1'b0;  vif.mono_en = 1'b0;
        vif.hs_in = 1'b1;  vif.vs_in = 1'b1;
        vif.plt_we = 1'b0;  vif.plt_adr = 3'd0;  vif.plt_data = 9'd0;  vif.bg_we = 1'b0;
    endtask

    function automatic logic [31:0] rgb();
        return 32'({vif.vga_r, vif.vga_g, vif.vga_b});
    endfunction

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb",  rgb(), 32'h000);
        chk("rst_sync", 32'({vif.vga_hs, vif.vga_vs}), 32'h3);
        chk("rst_pend", 32'(vif.plt_pending), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Default palette entry 5 and sync delay
        px(3'd5);
        for (int i = 0; i < 6; i++) begin
            vif.hs_in = 1'(i % 2);
            cyc();
        end
        chk("idx5", rgb(), 32'h0FF);

        // Shadowed write, visible only after the vsync falling edge
        px(3'd2);
        vif.plt_we = 1'b1;  vif.plt_adr = 3'd2;  vif.plt_data = 9'o047;
        cyc();
        vif.plt_we = 1'b0;
        chk("pend_set", 32'(vif.plt_pending), 32'h1);
        run(3);
        chk("idx2_old", rgb(), 32'hF00);
        vif.vs_in = 1'b0;
        run(3);
        chk("idx2_new", rgb(), 32'h90F);
        chk("pend_clr", 32'(vif.plt_pending), 32'h0);
        vif.vs_in = 1'b1;
        run(2);

        // Write coinciding with commit: old shadow commits, new one waits
        vif.plt_we = 1'b1;  vif.plt_data = 9'o700;
        cyc();
        vif.plt_we = 1'b0;
        run(2);
        vif.vs_in = 1'b0;  vif.plt_we = 1'b1;  vif.plt_data = 9'o070;
        cyc();
        vif.plt_we = 1'b0;
        chk("pend_keep", 32'(vif.plt_pending), 32'h1);
        run(2);
        chk("commit_old", rgb(), 32'h0F0);
        vif.vs_in = 1'b1;
        run(3);
        chk("still_old", rgb(), 32'h0F0);
        vif.vs_in = 1'b0;
        run(3);
        chk("commit_new", rgb(), 32'hF00);
        chk("pend_clr2", 32'(vif.plt_pending), 32'h0);
        vif.vs_in = 1'b1;
        run(2);

        // Scanline dimming
        px(3'd7);  vif.scan_en = 1'b1;  vif.scanln = 1'b1;
        run(3);
        chk("scan_on", rgb(), 32'h777);
        vif.scanln = 1'b0;
        run(3);
        chk("scan_off", rgb(), 32'hFFF);
        vif.scan_en = 1'b0;

        // Mono with bright and black background, then blanking
        vif.bg_we = 1'b1;  vif.plt_data = 9'o777;
        cyc();
        vif.bg_we = 1'b0;  vif.mono_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vif.lumi = 1'(i % 2);
            cyc();
        end
        vif.lumi = 1'b0;
        run(3);
        chk("mono_bg7", rgb(), 32'hFFF);
        vif.bg_we = 1'b1;  vif.plt_data = 9'o000;
        cyc();
        vif.bg_we = 1'b0;
        run(3);
        chk("mono_bg0", rgb(), 32'h000);
        vif.lumi = 1'b1;
        run(3);
        chk("mono_on", rgb(), 32'hFFF);
        vif.vsafe = 1'b0;
        run(3);
        chk("blank", rgb(), 32'h000);
        idle_inputs();
        run(3);

        // Randomised traffic with periodic vsync pulses
        for (int n = 0; n < 1500; n++) begin
            px(3'($urandom_range(0, 7)));
            vif.lumi     = 1'($urandom_range(0, 1));
            vif.vsafe    = ($urandom_range(0, 7) != 0);
            vif.scanln   = 1'($urandom_range(0, 1));
            vif.scan_en  = 1'($urandom_range(0, 1));
            vif.mono_en  = ($urandom_range(0, 3) == 0);
            vif.hs_in    = 1'($urandom_range(0, 1));
            vif.vs_in    = (n % 50 < 44) ? 1'b1 : ($urandom_range(0, 3) != 0);
            vif.plt_we   = ($urandom_range(0, 7) == 0);
            vif.plt_adr  = 3'($urandom_range(0, 7));
            vif.plt_data = 9'($urandom_range(0, 511));
            vif.bg_we    = ($urandom_range(0, 15) == 0);
            cyc();
        end

        // Reprogram entry 3, then reset mid-line
        idle_inputs();
        run(3);
        vif.plt_we = 1'b1;  vif.plt_adr = 3'd3;  vif.plt_data = 9'o111;
        cyc();
        vif.plt_we = 1'b0;  vif.vs_in = 1'b0;
        cyc();
        vif.vs_in = 1'b1;  px(3'd3);  vif.hs_in = 1'b0;
        run(3);
        chk("idx3_prog", rgb(), 32'h222);
        vif.plt_we = 1'b1;  vif.plt_adr = 3'd0;  vif.plt_data = 9'o123;
        cyc();
        vif.plt_we = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_rgb",  rgb(), 32'h000);
        chk("mid_rst_sync", 32'({vif.vga_hs, vif.vga_vs}), 32'h3);
        chk("mid_rst_pend", 32'(vif.plt_pending), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        vif.hs_in = 1'b1;
        run(3);
        chk("idx3_default", rgb(), 32'hF0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_color_out.md
Name: vga_color_out

Overview:
- Final video stage directly downstream of the CRTC's VGA line-buffer outputs.
- Takes the per-dot colour index (dot_g, dot_r, dot_b), luminance (lumi), the visible window (vsafe), the scanline phase (scanln) and the VGA syncs.
- Maps each dot through an 8-entry programmable colour palette and applies optional scanline dimming and monochrome mode.
- Drives 4-bit-per-channel VGA RGB, with the syncs delayed to match.
- Palette writes are shadowed and committed at vertical sync, so a frame never shows mixed palettes.

Parameters:
- PIPE_LAT, 3, pixel pipeline depth in clk cycles; sync delay equals this. Only 3 is supported.
- IMMEDIATE, 0, when 1 a palette write goes straight to the active palette and bypasses the shadow/commit.

Ports:
- clk  in  1  VGA dot clock, the same domain as the CRTC line-buffer read side.
- reset  in  1  Asynchronous, active-high reset.
- dot_b  in  1  Colour index bit 0.
- dot_r  in  1  Colour index bit 1.
- dot_g  in  1  Colour index bit 2.
- lumi  in  1  Dot on (1) or background (0).
- vsafe  in  1  Inside the visible window.
- scanln  in  1  Odd VGA line when 1.
- scan_en  in  1  Scanline effect enable (SW #1).
- mono_en  in  1  Monochrome output enable.
- hs_in  in  1  VGA hsync, active low.
- vs_in  in  1  VGA vsync, active low.
- plt_we  in  1  Palette write strobe, one cycle, synchronous to clk.
- plt_adr  in  3  Palette entry index.
- plt_data  in  9  Entry value: [8:6]=G, [5:3]=R, [2:0]=B, 3 bits per channel.
- bg_we  in  1  Background colour write strobe.
- vga_r  out  4  Red output.
- vga_g  out  4  Green output.
- vga_b  out  4  Blue output.
- vga_hs  out  1  Delayed hsync, active low.
- vga_vs  out  1  Delayed vsync, active low.
- plt_pending  out  1  1 while shadow writes are waiting for commit.

Behaviour:
- Reset values:
  - vga_r/g/b = 0.
  - vga_hs = vga_vs = 1.
  - plt_pending = 0.
  - Background register = 0.
  - Active and shadow palette entry i = {G=i[2]?7:0, R=i[1]?7:0, B=i[0]?7:0}, i.e. the 8 digital colours.
  - All pipeline registers cleared.
- Pipeline, 3 stages:
  - S1 registers the inputs.
  - S2 looks up active[{dot_g,dot_r,dot_b}]; if lumi=0 the background register is selected instead.
  - S3 applies mono, scanline and blanking, then registers the outputs.
  - A change at the input pins appears on vga_* exactly 3 clk edges later.
  - hs_in/vs_in pass through a 3-deep shift register, so they stay aligned with the pixels.
- Channel expansion: 3-bit value c maps to 4-bit {c, c[2]}. So 7 maps to F, 0 maps to 0, 4 maps to 9.
- Mono (mono_en=1): all three channels equal F when lumi=1, and equal the expanded background G field when lumi=0. Palette ignored.
- Scanline: if scan_en=1 and scanln=1 (S2-aligned), each 4-bit channel is shifted right by 1. F becomes 7.
- Blanking: if vsafe=0 (aligned), outputs are 0. Blanking overrides mono and scanline.
- Palette writes, IMMEDIATE=0:
  - plt_we writes shadow[plt_adr] and sets plt_pending=1.
  - Commit happens on the cycle the vs_in falling edge is detected. An edge is vs_in=0 while its S1 copy is 1.
  - On commit, active <= shadow for all 8 entries and plt_pending <= 0.
  - If plt_we coincides with commit, the commit copies the pre-write shadow. The new write lands in shadow and plt_pending stays 1, so it commits at the next vsync.
- Palette writes, IMMEDIATE=1: writes go to both shadow and active in the same cycle; plt_pending stays 0.
- bg_we loads the background register from plt_data immediately, with no shadowing.
- A mid-frame reset takes effect asynchronously: outputs go black and the syncs go high. Normal operation resumes 3 cycles after reset is released, and the palette returns to its defaults.
- Palette writes while vs_in is held low with no new falling edge stay pending.

Test Plan:
- Reset released, vsafe=1, lumi=1, index 5 (g=1,r=0,b=1) -> 3 cycles later vga_r=0, vga_g=F, vga_b=F; vga_hs/vs follow hs_in/vs_in delayed 3 cycles.
- Write plt_adr=2, plt_data=9'o047 (G=0,R=4,B=7) mid-frame -> plt_pending=1 and index 2 still outputs R=F,G=0,B=0. After the next vs_in falling edge: R=9, G=0, B=F, and plt_pending=0.
- plt_we in the same cycle as the vsync commit -> old shadow committed, plt_pending stays 1, and the new value appears only after the following vsync.
- scan_en=1, scanln=1, index 7 -> outputs 7,7,7. scanln=0 -> F,F,F.
- mono_en=1, lumi alternating 1/0 with background 9'o777 -> outputs alternate F/F/F and F/F/F; with background 0 they alternate F and 0. vsafe=0 -> 0 regardless.
- Assert reset mid-line while outputs are non-zero -> outputs are immediately 0 and syncs 1. After release, index 3 shows the default R=F,G=0,B=F even though it was reprogrammed before reset.
